// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU types for the common data bus: reservation-station tags and the
// tag/value broadcast record snooped by every consumer.
package cpu_types;

    typedef logic [4:0] RS_tag_type;

    // Tag value meaning "no result"; real RS tags start at 1.
    localparam RS_tag_type INVALID = 5'd0;

    typedef struct packed {
        RS_tag_type  tag;
        logic [31:0] data;
    } cdb_t;

    localparam int CDB_NUM_FU = 4;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result ports and the CDB broadcast, bundled for the arbiter and its users.
interface cdb_arbiter_if #(
    parameter int NUM_FU = cpu_types::CDB_NUM_FU
);
    import cpu_types::*;

    logic                    FLUSH;
    logic [NUM_FU-1:0]       fu_valid;
    RS_tag_type [NUM_FU-1:0] fu_tag;
    logic [NUM_FU-1:0][31:0] fu_data;
    logic [NUM_FU-1:0]       fu_ready;
    cdb_t                    cdb_out;
    logic [NUM_FU-1:0]       cdb_grant;

    modport master (
        output FLUSH, fu_valid, fu_tag, fu_data,
        input  fu_ready, cdb_out, cdb_grant
    );

    modport slave (
        input  FLUSH, fu_valid, fu_tag, fu_data,
        output fu_ready, cdb_out, cdb_grant
    );

endinterface

// File: rtl/cdb_fifo.sv
// Per-FU result buffer: DEPTH-entry FIFO of CDB records with synchronous flush.
module cdb_fifo
    import cpu_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  cdb_t din,
    output logic full,
    output logic empty,
    output cdb_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    cdb_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers FU results and broadcasts one per cycle on the registered CDB,
// choosing among non-empty buffers round-robin.
module cdb_arbiter
    import cpu_types::*;
#(
    parameter int NUM_FU = CDB_NUM_FU,
    parameter int DEPTH  = 2
) (
    input  logic         CLK,
    input  logic         RST_N,
    cdb_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] push_w, pop_w, full_w, empty_w, req_w;
    cdb_t              head_w [NUM_FU];

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    cdb_t              cdb_q, cdb_d;
    logic [NUM_FU-1:0] grant_q, grant_d;

    logic [NUM_FU-1:0] req_rot;
    logic [PTR_W-1:0]  rot_idx;
    logic [PTR_W-1:0]  winner;
    logic              found;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_FU) s = s - NUM_FU;
        return PTR_W'(s);
    endfunction

    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
        cdb_t din;

        assign din        = '{tag: bus.fu_tag[gi], data: bus.fu_data[gi]};
        // INVALID-tagged results complete the handshake but are dropped here.
        assign push_w[gi] = bus.fu_valid[gi] & ~full_w[gi] & (bus.fu_tag[gi] != INVALID);

        cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .CLK   (CLK),
            .RST_N (RST_N),
            .flush (bus.FLUSH),
            .push  (push_w[gi]),
            .pop   (pop_w[gi]),
            .din   (din),
            .full  (full_w[gi]),
            .empty (empty_w[gi]),
            .head  (head_w[gi])
        );
    end

    assign req_w         = ~empty_w;
    assign bus.fu_ready  = ~full_w;
    assign bus.cdb_out   = cdb_q;
    assign bus.cdb_grant = grant_q;

    // Rotate so rr_ptr sits at bit 0, take the lowest request, rotate back.
    always_comb begin
        req_rot = '0;
        rot_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            req_rot[k] = req_w[wrap_add(rr_ptr_q, k)];
        end
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found   = 1'b1;
                rot_idx = PTR_W'(k);
            end
        end
        winner = wrap_add(rr_ptr_q, int'(rot_idx));

        pop_w       = '0;
        grant_d     = '0;
        cdb_d       = cdb_q;
        cdb_d.tag   = INVALID;
        rr_ptr_d    = rr_ptr_q;
        if (bus.FLUSH) begin
            rr_ptr_d = '0;
        end else if (found) begin
            pop_w[winner]   = 1'b1;
            grant_d[winner] = 1'b1;
            cdb_d           = head_w[winner];
            rr_ptr_d        = wrap_add(winner, 1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_ptr_q <= '0;
            cdb_q    <= '{tag: INVALID, data: 32'd0};
            grant_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
            grant_q  <= grant_d;
        end
    end

endmodule
